// File: rtl/lsu_pkg.sv
// Shared types for the LSU-to-dcache bridge: size/opcode encodings, FSM states and
// the request queue entry layout.
package lsu_pkg;

  localparam int unsigned LSU_XLEN      = 64;
  localparam int unsigned LSU_VADDR_LEN = 39;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } lsu_size_e;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } lsu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } lsu_state_e;

  typedef struct packed {
    logic [LSU_VADDR_LEN-1:0] addr;
    logic [LSU_XLEN-1:0]      data;
    lsu_op_e                  op;
    lsu_size_e                size;
  } lsu_entry_t;

endpackage

// File: rtl/lsu_req_fifo.sv
// Synchronous request FIFO with wrap-bit pointers; flush empties it on the next edge.
module lsu_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  // Same index with differing wrap bits means the pointers are a full lap apart.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/lsu_dcache_bridge.sv
// Bridges LSU byte-granular requests to 8-byte-lane dcache accesses, one outstanding at a time.
// Optional LSU_DCACHE_BRIDGE_BYPASS_EN: idle+empty requests reach the dcache the same cycle.
module lsu_dcache_bridge
  import lsu_pkg::*;
#(
  parameter int XLEN             = 64,
  parameter int VIRTUAL_ADDR_LEN = 39,
  parameter int DEPTH            = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        lsu_req_valid_i,
  output logic                        lsu_req_ready_o,
  input  logic [VIRTUAL_ADDR_LEN-1:0] lsu_req_addr_i,
  input  logic [XLEN-1:0]             lsu_req_data_i,
  input  logic                        lsu_req_opcode_i,
  input  logic [1:0]                  lsu_req_size_i,
  output logic                        lsu_resp_valid_o,
  input  logic                        lsu_resp_ready_i,
  output logic [XLEN-1:0]             lsu_resp_data_o,
  output logic                        mem_req_valid_o,
  input  logic                        mem_req_ready_i,
  output logic [VIRTUAL_ADDR_LEN-1:0] mem_req_addr_o,
  output logic                        mem_req_we_o,
  output logic [XLEN-1:0]             mem_req_wdata_o,
  output logic [7:0]                  mem_req_wmask_o,
  input  logic                        mem_resp_valid_i,
  input  logic [XLEN-1:0]             mem_resp_rdata_i
);

`ifdef LSU_DCACHE_BRIDGE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  function automatic logic [7:0] lane_mask(input lsu_size_e size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      SIZE_B:  m = 8'h01;
      SIZE_H:  m = 8'h03;
      SIZE_W:  m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  function automatic logic [XLEN-1:0] align_store(input logic [XLEN-1:0] d,
                                                  input logic [2:0] off);
    return d << {off, 3'b000};
  endfunction

  function automatic logic [XLEN-1:0] extract_load(input logic [XLEN-1:0] r,
                                                   input lsu_size_e size,
                                                   input logic [2:0] off);
    logic [XLEN-1:0] s;
    logic [XLEN-1:0] keep;
    s = r >> {off, 3'b000};
    case (size)
      SIZE_B:  keep = XLEN'(8'hFF);
      SIZE_H:  keep = XLEN'(16'hFFFF);
      SIZE_W:  keep = XLEN'(32'hFFFF_FFFF);
      default: keep = '1;
    endcase
    return s & keep;
  endfunction

  lsu_state_e      state, state_nxt;
  lsu_entry_t      in_entry, head_entry, cur_entry;
  logic            fifo_full, fifo_empty;
  logic            accept, push, pop, byp_sel, mem_fire;
  lsu_op_e         infl_op_p1;
  lsu_size_e       infl_size_p1;
  logic [2:0]      infl_off_p1;
  logic [XLEN-1:0] resp_data_p1;

  assign in_entry.addr = lsu_req_addr_i;
  assign in_entry.data = lsu_req_data_i;
  assign in_entry.op   = lsu_op_e'(lsu_req_opcode_i);
  assign in_entry.size = lsu_size_e'(lsu_req_size_i);

  assign lsu_req_ready_o = !fifo_full && !flush_i;
  assign accept          = lsu_req_valid_i && lsu_req_ready_o;
  assign byp_sel         = BYPASS_EN && (state == ST_IDLE) && fifo_empty && accept;
  // A bypassed request that the dcache does not take immediately still lands in the
  // FIFO, so the REQ state replays the identical payload next cycle.
  assign push            = accept && !(byp_sel && mem_req_ready_i);
  assign pop             = (state == ST_REQ) && mem_req_ready_i;

  lsu_req_fifo #(
    .WIDTH($bits(lsu_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(flush_i),
    .push (push),
    .wdata(in_entry),
    .pop  (pop),
    .rdata(head_entry),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Request stage p0: payload straight from FIFO head (or LSU inputs when bypassing)
  assign cur_entry       = byp_sel ? in_entry : head_entry;
  assign mem_req_valid_o = (state == ST_REQ) || byp_sel;
  assign mem_fire        = mem_req_valid_o && mem_req_ready_i;
  assign mem_req_addr_o  = mem_req_valid_o ?
                           {cur_entry.addr[VIRTUAL_ADDR_LEN-1:3], 3'b000} : '0;
  assign mem_req_we_o    = mem_req_valid_o && (cur_entry.op == OP_STORE);
  assign mem_req_wmask_o = mem_req_we_o ? lane_mask(cur_entry.size, cur_entry.addr[2:0]) : '0;
  assign mem_req_wdata_o = mem_req_we_o ? align_store(cur_entry.data, cur_entry.addr[2:0]) : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (!flush_i) begin
          if (byp_sel && mem_req_ready_i)  state_nxt = ST_WAIT;
          else if (accept || !fifo_empty)  state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // A flush racing the handshake still leaves a response owed by the dcache.
        if (flush_i)              state_nxt = mem_req_ready_i ? ST_DRAIN : ST_IDLE;
        else if (mem_req_ready_i) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid_i)     state_nxt = flush_i ? ST_IDLE : ST_RESP;
        else if (flush_i)         state_nxt = ST_DRAIN;
      end
      ST_RESP: begin
        if (flush_i || lsu_resp_ready_i) state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (mem_resp_valid_i)     state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // In-flight stage p1: remember how to format the response for the accepted request
  always_ff @(posedge clk) begin
    if (mem_fire) begin
      infl_op_p1   <= cur_entry.op;
      infl_size_p1 <= cur_entry.size;
      infl_off_p1  <= cur_entry.addr[2:0];
    end
    if ((state == ST_WAIT) && mem_resp_valid_i) begin
      resp_data_p1 <= (infl_op_p1 == OP_STORE) ? '0 :
                      extract_load(mem_resp_rdata_i, infl_size_p1, infl_off_p1);
    end
  end

  assign lsu_resp_valid_o = (state == ST_RESP);
  assign lsu_resp_data_o  = lsu_resp_valid_o ? resp_data_p1 : '0;

endmodule

// File: tb/tb_lsu_dcache_bridge.sv
// Directed, table-driven bench for lsu_dcache_bridge plus queue-full, flush and reset sequences.
module tb_lsu_dcache_bridge;

  localparam int XLEN  = 64;
  localparam int VA    = 39;
  localparam int DEPTH = 4;
`ifdef LSU_DCACHE_BRIDGE_BYPASS_EN
  localparam bit EXP_BYP = 1'b1;
`else
  localparam bit EXP_BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_i;
  logic            lsu_req_valid_i;
  logic            lsu_req_ready_o;
  logic [VA-1:0]   lsu_req_addr_i;
  logic [XLEN-1:0] lsu_req_data_i;
  logic            lsu_req_opcode_i;
  logic [1:0]      lsu_req_size_i;
  logic            lsu_resp_valid_o;
  logic            lsu_resp_ready_i;
  logic [XLEN-1:0] lsu_resp_data_o;
  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic [VA-1:0]   mem_req_addr_o;
  logic            mem_req_we_o;
  logic [XLEN-1:0] mem_req_wdata_o;
  logic [7:0]      mem_req_wmask_o;
  logic            mem_resp_valid_i;
  logic [XLEN-1:0] mem_resp_rdata_i;

  lsu_dcache_bridge #(.XLEN(XLEN), .VIRTUAL_ADDR_LEN(VA), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .lsu_req_valid_i  (lsu_req_valid_i),
    .lsu_req_ready_o  (lsu_req_ready_o),
    .lsu_req_addr_i   (lsu_req_addr_i),
    .lsu_req_data_i   (lsu_req_data_i),
    .lsu_req_opcode_i (lsu_req_opcode_i),
    .lsu_req_size_i   (lsu_req_size_i),
    .lsu_resp_valid_o (lsu_resp_valid_o),
    .lsu_resp_ready_i (lsu_resp_ready_i),
    .lsu_resp_data_o  (lsu_resp_data_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_we_o     (mem_req_we_o),
    .mem_req_wdata_o  (mem_req_wdata_o),
    .mem_req_wmask_o  (mem_req_wmask_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_rdata_i (mem_resp_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            op;
    logic [1:0]      size;
    logic [VA-1:0]   addr;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] rdata;
    logic [VA-1:0]   exp_addr;
    logic            exp_we;
    logic [7:0]      exp_wmask;
    logic [XLEN-1:0] exp_wdata;
    logic [XLEN-1:0] exp_resp;
  } vec_t;

  vec_t vecs [9];
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   acc_target = 0;
  bit   auto_drop = 1'b0;

  always @(negedge clk) begin
    if (lsu_req_valid_i && lsu_req_ready_o && !rst) acc_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop && acc_cnt >= acc_target) lsu_req_valid_i = 1'b0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_req(input logic op, input logic [1:0] size, input logic [VA-1:0] addr,
                         input logic [XLEN-1:0] data);
    lsu_req_opcode_i = op;
    lsu_req_size_i   = size;
    lsu_req_addr_i   = addr;
    lsu_req_data_i   = data;
  endtask

  task automatic run_vec(input vec_t v);
    set_req(v.op, v.size, v.addr, v.data);
    lsu_req_valid_i = 1'b1;
    settle();
    chk("req_ready", 64'(lsu_req_ready_o), 64'(1));
    chk("accept_cycle_valid", 64'(mem_req_valid_o), 64'(EXP_BYP));
    tick();
    lsu_req_valid_i = 1'b0;
    settle();
    chk("mem_valid", 64'(mem_req_valid_o), 64'(1));
    chk("mem_addr", 64'(mem_req_addr_o), 64'(v.exp_addr));
    chk("mem_we", 64'(mem_req_we_o), 64'(v.exp_we));
    chk("mem_wmask", 64'(mem_req_wmask_o), 64'(v.exp_wmask));
    chk("mem_wdata", mem_req_wdata_o, v.exp_wdata);
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    settle();
    chk("wait_valid_low", 64'(mem_req_valid_o), 64'(0));
    chk("wait_no_resp", 64'(lsu_resp_valid_o), 64'(0));
    mem_resp_valid_i = 1'b1;
    mem_resp_rdata_i = v.rdata;
    tick();
    mem_resp_valid_i = 1'b0;
    mem_resp_rdata_i = 64'h5A5A_5A5A_5A5A_5A5A;
    settle();
    chk("resp_valid", 64'(lsu_resp_valid_o), 64'(1));
    chk("resp_data", lsu_resp_data_o, v.exp_resp);
    tick();
    chk("resp_hold_valid", 64'(lsu_resp_valid_o), 64'(1));
    chk("resp_hold_data", lsu_resp_data_o, v.exp_resp);
    lsu_resp_ready_i = 1'b1;
    tick();
    lsu_resp_ready_i = 1'b0;
    settle();
    chk("resp_done", 64'(lsu_resp_valid_o), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    //            op    sz    addr         data                    rdata                   exp_addr     we    wmask  exp_wdata               exp_resp
    vecs[0] = '{1'b1, 2'd3, 39'h1000, 64'h1122334455667788, 64'hDEADBEEFDEADBEEF, 39'h1000, 1'b1, 8'hFF, 64'h1122334455667788, 64'h0};
    vecs[1] = '{1'b0, 2'd1, 39'h1006, 64'h0,                64'hABCD000000000000, 39'h1000, 1'b0, 8'h00, 64'h0,                64'hABCD};
    vecs[2] = '{1'b1, 2'd0, 39'h2003, 64'h5A,               64'hFFFFFFFFFFFFFFFF, 39'h2000, 1'b1, 8'h08, 64'h5A000000,         64'h0};
    vecs[3] = '{1'b0, 2'd2, 39'h2004, 64'h0,                64'h8765432100000000, 39'h2000, 1'b0, 8'h00, 64'h0,                64'h87654321};
    vecs[4] = '{1'b1, 2'd1, 39'h3002, 64'hBEEF,             64'h0,                39'h3000, 1'b1, 8'h0C, 64'hBEEF0000,         64'h0};
    vecs[5] = '{1'b0, 2'd0, 39'h4007, 64'h0,                64'hF100000000000000, 39'h4000, 1'b0, 8'h00, 64'h0,                64'hF1};
    vecs[6] = '{1'b0, 2'd3, 39'h5008, 64'h0,                64'h0123456789ABCDEF, 39'h5008, 1'b0, 8'h00, 64'h0,                64'h0123456789ABCDEF};
    vecs[7] = '{1'b1, 2'd2, 39'h6004, 64'hCAFEF00D,         64'h0,                39'h6000, 1'b1, 8'hF0, 64'hCAFEF00D00000000, 64'h0};
    vecs[8] = '{1'b0, 2'd0, 39'h7001, 64'h0,                64'h1122334455667788, 39'h7000, 1'b0, 8'h00, 64'h0,                64'h77};

    rst = 1'b1; flush_i = 1'b0; lsu_req_valid_i = 1'b0; lsu_resp_ready_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_rdata_i = '0;
    set_req(1'b0, 2'd0, '0, '0);
    repeat (3) tick();
    rst = 1'b0;
    settle();
    chk("rst_req_ready", 64'(lsu_req_ready_o), 64'(1));
    chk("rst_mem_valid", 64'(mem_req_valid_o), 64'(0));
    chk("rst_resp_valid", 64'(lsu_resp_valid_o), 64'(0));
    chk("rst_we", 64'(mem_req_we_o), 64'(0));
    chk("rst_addr", 64'(mem_req_addr_o), 64'(0));
    chk("rst_wmask", 64'(mem_req_wmask_o), 64'(0));
    chk("rst_wdata", mem_req_wdata_o, 64'(0));
    chk("rst_resp_data", lsu_resp_data_o, 64'(0));

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Five requests against a stalled dcache
    base = acc_cnt;
    mem_req_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_req(1'b0, 2'd3, 39'(32'h100 + 8 * k), '0);
      lsu_req_valid_i = 1'b1;
      settle();
      chk("q_ready", 64'(lsu_req_ready_o), 64'(1));
      tick();
    end
    set_req(1'b0, 2'd3, 39'h120, '0);
    settle();
    chk("q_full_ready_low", 64'(lsu_req_ready_o), 64'(0));
    chk("q_head_valid", 64'(mem_req_valid_o), 64'(1));
    chk("q_head_addr", 64'(mem_req_addr_o), 64'h100);
    acc_target = base + 5;
    auto_drop  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int w = 0; w < 10 && !mem_req_valid_o; w++) tick();
      chk("q_valid_seen", 64'(mem_req_valid_o), 64'(1));
      chk("q_order_addr", 64'(mem_req_addr_o), 64'(32'h100 + 8 * k));
      mem_req_ready_i = 1'b1;
      tick();
      mem_req_ready_i = 1'b0;
      mem_resp_valid_i = 1'b1;
      mem_resp_rdata_i = 64'hC0DE000000000000 | 64'(k);
      tick();
      mem_resp_valid_i = 1'b0;
      chk("q_resp_valid", 64'(lsu_resp_valid_o), 64'(1));
      chk("q_resp_data", lsu_resp_data_o, 64'hC0DE000000000000 | 64'(k));
      lsu_resp_ready_i = 1'b1;
      tick();
      lsu_resp_ready_i = 1'b0;
    end
    auto_drop = 1'b0;
    chk("q_accept_count", 64'(acc_cnt - base), 64'(5));

    // Flush while waiting on the dcache with two entries still queued
    lsu_req_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_req(1'b0, 2'd3, 39'(32'h200 + 8 * k), '0);
      tick();
    end
    lsu_req_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    flush_i = 1'b1;
    lsu_req_valid_i = 1'b1;
    set_req(1'b0, 2'd3, 39'h900, '0);
    settle();
    chk("flush_ready_low", 64'(lsu_req_ready_o), 64'(0));
    tick();
    flush_i = 1'b0;
    lsu_req_valid_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("drain_no_mem_req", 64'(mem_req_valid_o), 64'(0));
      tick();
    end
    mem_resp_valid_i = 1'b1;
    mem_resp_rdata_i = 64'h1234;
    tick();
    mem_resp_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("drain_no_resp", 64'(lsu_resp_valid_o), 64'(0));
      chk("drain_queue_empty", 64'(mem_req_valid_o), 64'(0));
      tick();
    end
    run_vec(vecs[1]);

    // Reset while a response is presented to the LSU
    set_req(1'b0, 2'd3, 39'h5008, '0);
    lsu_req_valid_i = 1'b1;
    tick();
    lsu_req_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b1;
    mem_resp_rdata_i = 64'h77;
    tick();
    mem_resp_valid_i = 1'b0;
    settle();
    chk("pre_rst_resp_valid", 64'(lsu_resp_valid_o), 64'(1));
    rst = 1'b1;
    tick();
    settle();
    chk("rst_resp_valid_mid", 64'(lsu_resp_valid_o), 64'(0));
    chk("rst_resp_data_mid", lsu_resp_data_o, 64'(0));
    chk("rst_mem_valid_mid", 64'(mem_req_valid_o), 64'(0));
    chk("rst_we_mid", 64'(mem_req_we_o), 64'(0));
    chk("rst_wmask_mid", 64'(mem_req_wmask_o), 64'(0));
    rst = 1'b0;
    tick();
    run_vec(vecs[6]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
